// File: rtl/i2c_regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_regbank_arbiter
// Purpose  : Arbitrates a single-port synchronous register bank between the
//            I2C slave application bus and an on-chip core req/ack port.
//            Fixed priority per bank access: I2C write > I2C prefetch > core.
//            The I2C side sees a byte register file whose read byte for the
//            current address is prefetched continuously.
// Ports    : clk, rst_n (synchronous, active-low)
//            i2c_addr/i2c_wen/i2c_wdata     - I2C write strobe and address
//            i2c_rdata_used -> i2c_rdata     - prefetched byte, used strobe
//            i2c_stale                       - sticky "used while not valid"
//            core_req/we/addr/wdata -> core_ack/core_rdata
//            mem_en/we/addr/wdata <- mem_rdata (1-cycle read latency)
//            wprot_hit                       - dropped protected I2C write
// Options  : `define REGBANK_WPROT_EN drops I2C writes at addresses
//            >= WPROT_ADDR; undefined, wprot_hit is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_regbank_arbiter #(
  parameter int          ADDR_W     = 8,
  parameter logic [7:0]  WPROT_ADDR = 8'hF0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i2c_addr,
  input  logic              i2c_wen,
  input  logic [7:0]        i2c_wdata,
  input  logic              i2c_rdata_used,
  output logic [7:0]        i2c_rdata,
  output logic              i2c_stale,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_wdata,
  output logic              core_ack,
  output logic [7:0]        core_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              wprot_hit
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_I2C_WR   = 3'd1;
  localparam logic [2:0] S_PF_RD    = 3'd2;
  localparam logic [2:0] S_PF_CAP   = 3'd3;
  localparam logic [2:0] S_CORE_ACC = 3'd4;
  localparam logic [2:0] S_CORE_CAP = 3'd5;

  logic [2:0]        state;
  logic              wr_pend;
  logic [7:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              pf_valid;
  logic [ADDR_W-1:0] pf_addr;
  logic [ADDR_W-1:0] pf_req_addr;

  // A strobe arriving in the grant cycle is served directly, so the
  // effective buffer content is the incoming byte when i2c_wen is high.
  logic [7:0]        eff_wr_addr;
  logic [7:0]        eff_wr_data;
  logic              wr_due;
  logic              wr_blocked;
  logic              pf_need;

  assign eff_wr_addr = i2c_wen ? i2c_addr  : wr_addr;
  assign eff_wr_data = i2c_wen ? i2c_wdata : wr_data;
  assign wr_due      = wr_pend || i2c_wen;
  assign pf_need     = !pf_valid || (i2c_addr[ADDR_W-1:0] != pf_addr);

`ifdef REGBANK_WPROT_EN
  assign wr_blocked = (eff_wr_addr >= WPROT_ADDR);
`else
  logic unused_wprot;
  assign unused_wprot = ^WPROT_ADDR;
  assign wr_blocked   = 1'b0;
`endif

  logic [2:0]        state_nx;
  logic              grant_wr;
  logic              mem_en_nx;
  logic              mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [7:0]        mem_wdata_nx;
  logic              wprot_nx;

  // Bank outputs are registered: they are computed here at the grant edge
  // and are therefore visible exactly during the access state.
  always_comb begin
    state_nx     = S_IDLE;
    grant_wr     = 1'b0;
    mem_en_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = '0;
    mem_wdata_nx = '0;
    wprot_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_due) begin
          state_nx = S_I2C_WR;
          grant_wr = 1'b1;
          if (wr_blocked) begin
            wprot_nx = 1'b1;
          end else begin
            mem_en_nx    = 1'b1;
            mem_we_nx    = 1'b1;
            mem_addr_nx  = eff_wr_addr[ADDR_W-1:0];
            mem_wdata_nx = eff_wr_data;
          end
        end else if (pf_need) begin
          state_nx    = S_PF_RD;
          mem_en_nx   = 1'b1;
          mem_addr_nx = i2c_addr[ADDR_W-1:0];
        end else if (core_req && !core_ack) begin
          // core_ack high means core_req still belongs to the finished access
          state_nx     = S_CORE_ACC;
          mem_en_nx    = 1'b1;
          mem_we_nx    = core_we;
          mem_addr_nx  = core_addr;
          mem_wdata_nx = core_wdata;
        end
      end
      S_I2C_WR:   state_nx = S_IDLE;
      S_PF_RD:    state_nx = S_PF_CAP;
      S_PF_CAP:   state_nx = S_IDLE;
      S_CORE_ACC: state_nx = mem_we ? S_IDLE : S_CORE_CAP;
      S_CORE_CAP: state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_pend     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      pf_valid    <= 1'b0;
      pf_addr     <= '0;
      pf_req_addr <= '0;
      i2c_rdata   <= '0;
      i2c_stale   <= 1'b0;
      core_ack    <= 1'b0;
      core_rdata  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wprot_hit   <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_en    <= mem_en_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      wprot_hit <= wprot_nx;

      if (i2c_wen) begin
        wr_addr <= i2c_addr;
        wr_data <= i2c_wdata;
      end
      if (grant_wr)
        wr_pend <= 1'b0;
      else if (i2c_wen)
        wr_pend <= 1'b1;

      if (state == S_PF_RD)
        pf_req_addr <= mem_addr;

      core_ack <= ((state == S_CORE_ACC) && mem_we) || (state == S_CORE_CAP);
      if (state == S_CORE_CAP)
        core_rdata <= mem_rdata;

      if (state == S_PF_CAP) begin
        i2c_rdata <= mem_rdata;
        pf_addr   <= pf_req_addr;
        pf_valid  <= 1'b1;
      end
      // Any bank write over the prefetched byte invalidates it (refetch).
      if (((state == S_I2C_WR) || (state == S_CORE_ACC)) &&
          mem_en && mem_we && (mem_addr == pf_addr))
        pf_valid <= 1'b0;
      // A consumed byte is always refetched, after the slave's increment.
      if (i2c_rdata_used) begin
        pf_valid <= 1'b0;
        if (!(pf_valid && (pf_addr == i2c_addr[ADDR_W-1:0])))
          i2c_stale <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_regbank_arbiter
// Purpose  : Directed self-checking bench for i2c_regbank_arbiter with a
//            behavioural single-port bank (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_regbank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i2c_addr;
  logic       i2c_wen;
  logic [7:0] i2c_wdata;
  logic       i2c_rdata_used;
  logic [7:0] i2c_rdata;
  logic       i2c_stale;
  logic       core_req;
  logic       core_we;
  logic [7:0] core_addr;
  logic [7:0] core_wdata;
  logic       core_ack;
  logic [7:0] core_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       wprot_hit;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_regbank_arbiter #(.ADDR_W(8), .WPROT_ADDR(8'hF0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_addr(i2c_addr), .i2c_wen(i2c_wen), .i2c_wdata(i2c_wdata),
    .i2c_rdata_used(i2c_rdata_used), .i2c_rdata(i2c_rdata), .i2c_stale(i2c_stale),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wprot_hit(wprot_hit)
  );

  // Bank model: preload values come from a function so only this process
  // ever writes the storage arrays.
  logic [7:0] bank [256];
  logic       bank_wr [256];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 8'hA5;
      8'h11:   return 8'h9B;
      8'h20:   return 8'h77;
      8'hFF:   return 8'hE1;
      8'h00:   return 8'h0E;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] bank_rd(input logic [7:0] a);
    return bank_wr[a] ? bank[a] : init_val(a);
  endfunction

  initial mem_rdata = 8'h00;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      bank[mem_addr]    <= mem_wdata;
      bank_wr[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= bank_wr[mem_addr] ? bank[mem_addr] : init_val(mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Core transfer: returns cycles from request to ack (99 if no ack seen).
  task automatic core_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
    core_req   = 1'b1;
    core_we    = we;
    core_addr  = a;
    core_wdata = d;
    lat = 99;
    rd  = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (core_ack) begin
        lat = k;
        rd  = core_rdata;
        break;
      end
    end
    core_req = 1'b0;
    core_we  = 1'b0;
    tick();
  endtask

  int         lat;
  logic [7:0] rd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      bank_wr[i] = 1'b0;
      bank[i]    = 8'h00;
    end
    rst_n = 1'b0; i2c_addr = 8'h10; i2c_wen = 1'b0; i2c_wdata = 8'h00;
    i2c_rdata_used = 1'b0; core_req = 1'b0; core_we = 1'b0;
    core_addr = 8'h00; core_wdata = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_rdata", {8'h0, i2c_rdata}, 16'h0);
    chk("rst_stale", {15'h0, i2c_stale}, 16'h0);
    chk("rst_ack",   {15'h0, core_ack}, 16'h0);
    chk("rst_mem_en", {15'h0, mem_en}, 16'h0);
    chk("rst_mem_addr", {8'h0, mem_addr}, 16'h0);
    chk("rst_wprot", {15'h0, wprot_hit}, 16'h0);

    // Initial prefetch of 0x10: PF_RD next cycle, byte after three
    rst_n = 1'b1;
    tick();
    chk("pf_rd_en",   {15'h0, mem_en}, 16'h1);
    chk("pf_rd_we",   {15'h0, mem_we}, 16'h0);
    chk("pf_rd_addr", {8'h0, mem_addr}, 16'h10);
    tick();
    chk("pf_not_yet", {8'h0, i2c_rdata}, 16'h0);
    tick();
    chk("pf_rdata", {8'h0, i2c_rdata}, 16'hA5);
    chk("pf_stale", {15'h0, i2c_stale}, 16'h0);

    // Used while valid: no stale, but refetch follows
    i2c_rdata_used = 1'b1;
    tick();
    i2c_rdata_used = 1'b0;
    chk("used_ok_stale", {15'h0, i2c_stale}, 16'h0);
    tick();
    chk("used_refetch", {15'h0, mem_en}, 16'h1);
    tick(); tick(); tick();

    // I2C write 0x10 <- 0x3C, then refetch returns 0x3C
    i2c_wen = 1'b1; i2c_wdata = 8'h3C;
    tick();
    i2c_wen = 1'b0;
    chk("wr_mem_en", {15'h0, mem_en}, 16'h1);
    chk("wr_mem_we", {15'h0, mem_we}, 16'h1);
    chk("wr_mem_addr", {8'h0, mem_addr}, 16'h10);
    chk("wr_mem_wdata", {8'h0, mem_wdata}, 16'h3C);
    tick();
    chk("wr_idle", {15'h0, mem_en}, 16'h0);
    tick();
    chk("wr_refetch_rd", {14'h0, mem_en, mem_we}, 16'h2);
    tick();
    chk("wr_old_byte", {8'h0, i2c_rdata}, 16'hA5);
    tick();
    chk("wr_new_byte", {8'h0, i2c_rdata}, 16'h3C);

    // Core read / write / read-back
    core_xfer(1'b0, 8'h20, 8'h00, lat, rd);
    chk("core_rd_lat", lat[15:0], 16'd3);
    chk("core_rd_data", {8'h0, rd}, 16'h77);
    chk("core_ack_drop", {15'h0, core_ack}, 16'h0);
    core_xfer(1'b1, 8'h20, 8'h11, lat, rd);
    chk("core_wr_lat", lat[15:0], 16'd2);
    chk("core_wr_bank", {8'h0, bank_rd(8'h20)}, 16'h11);
    core_xfer(1'b0, 8'h20, 8'h00, lat, rd);
    chk("core_rb_data", {8'h0, rd}, 16'h11);

    // Simultaneous I2C write and core write: I2C first
    i2c_addr = 8'h40; i2c_wen = 1'b1; i2c_wdata = 8'h55;
    core_req = 1'b1; core_we = 1'b1; core_addr = 8'h21; core_wdata = 8'h66;
    tick();
    i2c_wen = 1'b0; i2c_addr = 8'h10;
    chk("sim_first", {mem_en, mem_we, 6'h0, mem_addr}, {2'b11, 6'h0, 8'h40});
    chk("sim_first_d", {8'h0, mem_wdata}, 16'h55);
    tick();
    chk("sim_gap_ack", {15'h0, core_ack}, 16'h0);
    tick();
    chk("sim_second", {mem_en, mem_we, 6'h0, mem_addr}, {2'b11, 6'h0, 8'h21});
    tick();
    chk("sim_ack", {15'h0, core_ack}, 16'h1);
    core_req = 1'b0; core_we = 1'b0;
    chk("sim_bank40", {8'h0, bank_rd(8'h40)}, 16'h55);
    chk("sim_bank21", {8'h0, bank_rd(8'h21)}, 16'h66);
    tick();

    // Stale: used one cycle after the address moved
    i2c_addr = 8'h11;
    tick();
    i2c_rdata_used = 1'b1;
    tick();
    i2c_rdata_used = 1'b0;
    chk("stale_set", {15'h0, i2c_stale}, 16'h1);
    tick();
    chk("stale_byte", {8'h0, i2c_rdata}, 16'h9B);
    tick(); tick(); tick(); tick();
    chk("stale_held", {15'h0, i2c_stale}, 16'h1);
    rst_n = 1'b0;
    tick();
    chk("stale_rst", {15'h0, i2c_stale}, 16'h0);
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("rst_refetch", {8'h0, i2c_rdata}, 16'h9B);

    // Protected address 0xF3
    i2c_addr = 8'hF3; i2c_wen = 1'b1; i2c_wdata = 8'hC7;
    tick();
    i2c_wen = 1'b0; i2c_addr = 8'h11;
`ifdef REGBANK_WPROT_EN
    chk("wp_mem_en", {15'h0, mem_en}, 16'h0);
    chk("wp_hit", {15'h0, wprot_hit}, 16'h1);
    tick();
    chk("wp_hit_pulse", {15'h0, wprot_hit}, 16'h0);
    chk("wp_bank", {8'h0, bank_rd(8'hF3)}, 16'hA9);
`else
    chk("wp_mem_en", {15'h0, mem_en}, 16'h1);
    chk("wp_hit", {15'h0, wprot_hit}, 16'h0);
    tick();
    chk("wp_bank", {8'h0, bank_rd(8'hF3)}, 16'hC7);
`endif
    core_xfer(1'b1, 8'hF3, 8'hD2, lat, rd);
    chk("wp_core_lat", lat[15:0], 16'd2);
    chk("wp_core_bank", {8'h0, bank_rd(8'hF3)}, 16'hD2);

    // Address wrap 0xFF -> 0x00
    i2c_addr = 8'hFF;
    tick(); tick(); tick();
    chk("wrap_ff", {8'h0, i2c_rdata}, 16'hE1);
    i2c_addr = 8'h00;
    tick(); tick(); tick();
    chk("wrap_00", {8'h0, i2c_rdata}, 16'h0E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_regbank_arbiter.md
Name: i2c_regbank_arbiter

Overview:
- Owns a single-port synchronous register bank shared by two requesters: the I2C slave application bus and an on-chip core port.
- On the I2C side it presents a byte register file: write pulses with addr/wdata, plus a continuously prefetched read byte for the current address.
- On the core side it runs a req/ack handshake.
- A fixed-priority FSM sequences all bank accesses: I2C write, then I2C prefetch, then core.

Parameters:
- ADDR_W, 8, bank address width; the I2C address is truncated to ADDR_W bits.
- WPROT_ADDR, 8'hF0, first I2C-write-protected address; used only with REGBANK_WPROT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i2c_addr  in  8  application address from the I2C slave
- i2c_wen  in  1  one-cycle write strobe
- i2c_wdata  in  8  write byte, valid with i2c_wen
- i2c_rdata_used  in  1  one-cycle strobe: the slave latched i2c_rdata
- i2c_rdata  out  8  prefetched byte for i2c_addr
- i2c_stale  out  1  sticky: i2c_rdata_used seen while the prefetch was not valid
- core_req  in  1  core request, held until core_ack
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  8  core write data
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  8  read data, valid with core_ack
- mem_en  out  1  bank access enable
- mem_we  out  1  bank write enable
- mem_addr  out  ADDR_W  bank address
- mem_wdata  out  8  bank write data
- mem_rdata  in  8  bank read data, valid the cycle after mem_en && !mem_we
- wprot_hit  out  1  one-cycle pulse when a protected I2C write is dropped

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State IDLE; wr_pend=0, pf_valid=0, pf_addr=0.
  - Outputs: i2c_rdata=0, i2c_stale=0, core_ack=0, core_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wprot_hit=0.
  - Reset mid-access aborts the access with no ack; core must re-request.
- I2C write capture, any state:
  - i2c_wen=1 latches i2c_addr and i2c_wdata into the write buffer and sets wr_pend.
  - A second strobe before service overwrites the buffer (latest wins).
- Prefetch demand: pf_need = !pf_valid || (i2c_addr[ADDR_W-1:0] != pf_addr).
- IDLE grant priority: wr_pend > pf_need > core_req.
  - I2C is sparse (≥9 SCL periods per byte), so the core cannot starve.
- States; mem_* are registered and driven in the access cycle only, else 0:
  - IDLE: no access.
  - I2C_WR (1 cycle): mem_en=1, mem_we=1, buffered addr/data; clears wr_pend. If buffer addr == pf_addr, clear pf_valid (forces refetch). Next state IDLE.
  - PF_RD: mem_en=1, mem_we=0, mem_addr=i2c_addr; record the requested addr. Next state PF_CAP.
  - PF_CAP: i2c_rdata<=mem_rdata, pf_addr<=recorded addr, pf_valid<=1. Next state IDLE.
    - If i2c_addr changed during PF_RD, pf_need re-asserts and another fetch follows.
  - CORE_ACC: mem_en=1, mem_we=core_we, core addr/data.
    - Write: core_ack=1 this cycle, next IDLE.
    - Read: next CORE_CAP.
  - CORE_CAP: core_rdata<=mem_rdata, core_ack=1. Next state IDLE.
  - Undefined encodings go to IDLE.
- Core write to pf_addr (CORE_ACC with core_we=1, matching addr) clears pf_valid.
- i2c_rdata_used:
  - If pf_valid=1 && pf_addr==i2c_addr, no action.
  - Otherwise set i2c_stale (held until reset).
  - In every case clear pf_valid, so the byte is refetched after the slave's address increment.
- Latency from IDLE with an idle bank:
  - core write ack = 2 cycles after the core_req edge is sampled.
  - core read ack = 3 cycles.
  - prefetch refresh = 3 cycles after the i2c_addr change.
- Simultaneous events:
  - i2c_wen together with core_req in IDLE: the write is served first; the core is granted afterwards unless a prefetch is due.
  - i2c_wen arriving during I2C_WR is captured into the buffer and served next.
- Address wrap: i2c_addr 0xFF→0x00 is an ordinary mismatch and triggers a refetch.

Optional Feature:
- Macro REGBANK_WPROT_EN.
- Defined:
  - An I2C write with buffered addr ≥ WPROT_ADDR is dropped in I2C_WR: mem_en=0, wr_pend cleared, wprot_hit=1 for that cycle, pf_valid untouched.
  - Core writes are never protected.
- Undefined: all I2C writes go to the bank; wprot_hit is tied to 0.

Test Plan:
- Reset, then i2c_addr=0x10 with bank[0x10]=0xA5 → PF_RD at 0x10; i2c_rdata=0xA5 three cycles later; i2c_stale=0.
- i2c_wen, addr 0x10, data 0x3C → I2C_WR cycle with mem_we=1; pf_valid cleared; refetch gives i2c_rdata=0x3C.
- core_req read 0x20 (bank=0x77), no I2C activity → core_ack at cycle 3, core_rdata=0x77; core write 0x20←0x11 → ack at cycle 2, bank[0x20]=0x11.
- i2c_wen and core_req write asserted in the same IDLE cycle → I2C_WR first, CORE_ACC second; both values land in the bank.
- i2c_rdata_used with i2c_addr changed one cycle earlier (prefetch in flight) → i2c_stale=1 and stays 1 until rst_n=0.
- With REGBANK_WPROT_EN, I2C write to 0xF3 → no mem_en, wprot_hit pulse, bank unchanged; core write to 0xF3 succeeds.
